// File: rtl/dm_access_sequencer_if.sv
// Request/response and byte-SRAM signal bundle for dm_access_sequencer.
// master = processor side plus SRAM model, slave = the sequencer itself.
interface dm_access_sequencer_if #(
    parameter int unsigned ADDR_W = 12
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_ctrl;
    logic [31:0]       req_address;
    logic [31:0]       req_data_in;
    logic              rsp_valid;
    logic [31:0]       rsp_data_out;
    logic              rsp_error;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_write, req_ctrl, req_address, req_data_in, mem_rdata,
        output req_ready, rsp_valid, rsp_data_out, rsp_error, busy,
        output mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_ctrl, req_address, req_data_in, mem_rdata,
        input  req_ready, rsp_valid, rsp_data_out, rsp_error, busy,
        input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );
endinterface

// File: rtl/dm_access_sequencer.sv
// Byte-serial load/store sequencer between the LSU and a byte-wide synchronous SRAM.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses are rejected via the error path.
module dm_access_sequencer #(
    parameter int unsigned ADDR_W = 12
) (
    input logic                    clk,
    input logic                    rst_n,
    dm_access_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StXfer, StLast, StResp} state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              write_q;
    logic [2:0]        ctrl_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wr_en_q;
    logic              mem_rd_en_q;
    logic [7:0]        mem_wdata_q;
    logic              rsp_valid_q;
    logic              rsp_error_q;
    logic [31:0]       rsp_data_q;

    function automatic logic [1:0] last_idx(input logic [2:0] ctrl);
        unique case (ctrl)
            3'b001, 3'b101: last_idx = 2'd1;
            3'b010:         last_idx = 2'd3;
            default:        last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] w);
        unique case (ctrl)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b100:  extend = {24'h0, w[7:0]};
            3'b101:  extend = {16'h0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    logic              accept;
    logic              req_err;
    logic [ADDR_W:0]   span_end;
    logic              misalign;
    logic [1:0]        last_k;
    logic [1:0]        k_prev;
    logic [1:0]        k_next;
    logic [31:0]       full_word;

    always_comb begin
        accept   = bus.req_valid && req_ready_q;
        // Extra top bit catches spans that run past the last SRAM byte.
        span_end = {1'b0, bus.req_address[ADDR_W-1:0]}
                 + {{(ADDR_W-1){1'b0}}, last_idx(bus.req_ctrl)};
`ifdef MISALIGN_TRAP_EN
        misalign = ((bus.req_ctrl[1:0] == 2'b01) && bus.req_address[0]) ||
                   ((bus.req_ctrl == 3'b010) && (bus.req_address[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err  = (bus.req_ctrl == 3'b011) || (bus.req_ctrl[2:1] == 2'b11) ||
                   (|bus.req_address[31:ADDR_W]) || span_end[ADDR_W] || misalign;
        last_k   = last_idx(ctrl_q);
        k_prev   = k_q - 2'd1;
        k_next   = k_q + 2'd1;
        full_word = rdata_q;
        full_word[{last_k, 3'b000} +: 8] = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            write_q     <= 1'b0;
            ctrl_q      <= 3'b000;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            k_q         <= 2'd0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wdata_q <= 8'h0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        ctrl_q      <= bus.req_ctrl;
                        wdata_q     <= bus.req_data_in;
                        rdata_q     <= 32'h0;
                        k_q         <= 2'd0;
                        if (req_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_data_q  <= 32'h0;
                        end else begin
                            state_q     <= StXfer;
                            mem_addr_q  <= bus.req_address[ADDR_W-1:0];
                            mem_wr_en_q <= bus.req_write;
                            mem_rd_en_q <= !bus.req_write;
                            mem_wdata_q <= bus.req_data_in[7:0];
                        end
                    end
                end
                StXfer: begin
                    // Read data lags the strobe by one cycle, so capture the previous byte.
                    if (!write_q && (k_q != 2'd0)) begin
                        rdata_q[{k_prev, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    if (k_q == last_k) begin
                        state_q     <= StLast;
                        mem_wr_en_q <= 1'b0;
                        mem_rd_en_q <= 1'b0;
                    end else begin
                        k_q         <= k_next;
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= wdata_q[{k_next, 3'b000} +: 8];
                    end
                end
                StLast: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b0;
                    rsp_data_q  <= write_q ? 32'h0 : extend(ctrl_q, full_word);
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_data_out = rsp_data_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wr_en    = mem_wr_en_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_sequencer.sv
// Self-checking bench for dm_access_sequencer: directed cases, then random requests against a
// byte-array reference memory. Honours MISALIGN_TRAP_EN the same way the design does.
module tb_dm_access_sequencer;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned MEM_SZ = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] last_rsp;

    logic [7:0] sram    [MEM_SZ];
    logic [7:0] ref_mem [MEM_SZ];

    dm_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    dm_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte SRAM: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_wr_en) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= sram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_err(input logic [2:0] c, input logic [31:0] a);
        int n = size_of(c);
        if (n == 0) return 1;
        if (a >= MEM_SZ) return 1;
        if (a + n > MEM_SZ) return 1;
`ifdef MISALIGN_TRAP_EN
        if (n > 1 && (a % n) != 0) return 1;
`endif
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] a);
        int n = size_of(c);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if ((c == 3'b000 || c == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Issues one request and checks strobes, latency, response and return to idle.
    task automatic run_req(input bit wr, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] d);
        int n = size_of(c);
        bit err = is_err(c, a);
        logic [31:0] exp_d = (!wr && !err) ? exp_load(c, a) : 32'h0;
        int exp_lat = err ? 1 : n + 2;
        int lat = 0;
        int bad = 0;
        int w = 0;
        logic rsp_err = 1'b0;
        logic [31:0] rsp_d = 32'h0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_ctrl    = c;
        bus.req_address = a;
        bus.req_data_in = d;
        @(posedge clk);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.req_valid = 1'b0;
                bus.req_data_in = $urandom();
                check("busy_c1", {31'h0, bus.busy}, 32'd1);
                check("ready_c1", {31'h0, bus.req_ready}, 32'd0);
            end
            begin
                bit act = !err && cyc <= n;
                logic [ADDR_W-1:0] ea = ADDR_W'(a + 32'(cyc - 1));
                if (bus.mem_wr_en !== (act && wr)) bad++;
                if (bus.mem_rd_en !== (act && !wr)) bad++;
                if (act && bus.mem_addr !== ea) bad++;
                if (act && wr && bus.mem_wdata !== d[8 * (cyc - 1) +: 8]) bad++;
            end
            if (bus.rsp_valid) begin
                lat = cyc;
                rsp_err = bus.rsp_error;
                rsp_d = bus.rsp_data_out;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_error", {31'h0, rsp_err}, {31'h0, err});
        check("rsp_data", rsp_d, exp_d);
        check("strobes", 32'(bad), 32'd0);
        @(negedge clk);
        check("rsp_pulse", {31'h0, bus.rsp_valid}, 32'd0);
        check("ready_back", {31'h0, bus.req_ready}, 32'd1);
        check("rsp_hold", bus.rsp_data_out, rsp_d);
        last_rsp = rsp_d;
        if (wr && !err) for (int i = 0; i < n; i++) ref_mem[a + i] = d[8 * i +: 8];
    endtask

    initial begin
        logic [31:0] sd;
        bit saw_rsp;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_ctrl = 3'b000;
        bus.req_address = 32'h0;
        bus.req_data_in = 32'h0;
        for (int i = 0; i < MEM_SZ; i++) begin
            sram[i] = 8'($urandom());
            ref_mem[i] = sram[i];
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, bus.req_ready}, 32'd0);
        check("rst_busy", {31'h0, bus.busy}, 32'd0);
        check("rst_strobes", {30'h0, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
        check("rst_rsp", {bus.rsp_data_out[30:0], bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1 check("ready_pre_edge", {31'h0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("ready_post_edge", {31'h0, bus.req_ready}, 32'd1);

        run_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h010, 32'h0);
        check("t2_word", last_rsp, 32'hDEADBEEF);

        sram[32'h20] = 8'h80; ref_mem[32'h20] = 8'h80;
        sram[32'h22] = 8'h34; ref_mem[32'h22] = 8'h34;
        sram[32'h23] = 8'hF2; ref_mem[32'h23] = 8'hF2;
        run_req(1'b0, 3'b000, 32'h020, 32'h0);
        check("t3_lb", last_rsp, 32'hFFFFFF80);
        run_req(1'b0, 3'b100, 32'h020, 32'h0);
        check("t3_lbu", last_rsp, 32'h00000080);
        run_req(1'b0, 3'b001, 32'h022, 32'h0);
        check("t3_lh", last_rsp, 32'hFFFFF234);
        run_req(1'b0, 3'b101, 32'h022, 32'h0);
        check("t3_lhu", last_rsp, 32'h0000F234);

        run_req(1'b0, 3'b111, 32'h010, 32'h0);
        run_req(1'b1, 3'b011, 32'h010, 32'h5);
        run_req(1'b0, 3'b010, 32'hFFE, 32'h0);
        run_req(1'b0, 3'b010, 32'h1000, 32'h0);
        run_req(1'b1, 3'b001, 32'hFFF, 32'h1234);
        run_req(1'b1, 3'b001, 32'hFFE, 32'hA5C3);
        run_req(1'b0, 3'b100, 32'hFFF, 32'h0);
        run_req(1'b1, 3'b010, 32'h011, 32'h12345678);
        run_req(1'b1, 3'b100, 32'h030, 32'h000000FE);
        run_req(1'b0, 3'b000, 32'h030, 32'h0);

        // Reset after two bytes of a word store: only those two bytes land.
        sd = $urandom();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_ctrl = 3'b010;
        bus.req_address = 32'h100;
        bus.req_data_in = sd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", {31'h0, bus.mem_wr_en}, 32'd0);
        check("abort_busy", {31'h0, bus.busy}, 32'd0);
        saw_rsp = bus.rsp_valid;
        repeat (3) begin
            @(negedge clk);
            saw_rsp |= bus.rsp_valid;
        end
        ref_mem[32'h100] = sd[7:0];
        ref_mem[32'h101] = sd[15:8];
        rst_n = 1'b1;
        #1 saw_rsp |= bus.rsp_valid;
        check("abort_no_rsp", {31'h0, saw_rsp}, 32'd0);
        @(negedge clk);
        check("abort_ready", {31'h0, bus.req_ready}, 32'd1);
        run_req(1'b0, 3'b010, 32'h100, 32'h0);

        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a;
            if (r < 6)      a = $urandom_range(0, 63);
            else if (r < 8) a = MEM_SZ - $urandom_range(1, 6);
            else if (r < 9) a = $urandom_range(MEM_SZ, MEM_SZ + 900);
            else            a = $urandom();
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
